clock_time_ctrl: RTL and testbench

- Central sequencer for the digital clock's seconds/minutes/hours counter chain.
- Divides the system clock into a 1 Hz tick and issues one-cycle add/clear pulses to each field counter.
- Propagates carries sec->min->hour in RUN mode; provides a button-driven set mode that selects one field and steps only that field.
- Sits between the key debouncers and the three field counters; drives the display blink enable.

---
 rtl/clock_time_ctrl.sv | 142 ++++++++++++++
 tb/tb_clock_time_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_ctrl.sv
// Sequencer for the sec/min/hour counter chain: 1 Hz prescaler, carry ripple in RUN,
// single-field stepping in the SET modes, and the selected-field blink enable.
//
// state       | meaning
// ST_RUN      | time advances on prescaler tick, carries ripple sec->min->hour
// ST_SET_HOUR | inc key steps hours only, hour field blinks
// ST_SET_MIN  | inc key steps minutes only, minute field blinks
// ST_SET_SEC  | inc key steps seconds only, second field blinks
module clock_time_ctrl #(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned BLINK_DIV = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       sec_carry,
  input  logic       min_carry,
  input  logic       hour_carry,
  output logic       sec_add,
  output logic       sec_end,
  output logic       min_add,
  output logic       min_end,
  output logic       hour_add,
  output logic       hour_end,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned BW = $clog2(BLINK_DIV);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_SET_SEC  = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_mode_q;
  logic            r_inc_q;
  logic [PW-1:0]   r_presc;
  logic [BW-1:0]   r_blink_cnt;
  logic            r_blink;
  logic            r_sec_add, r_sec_end;
  logic            r_min_add, r_min_end;
  logic            r_hour_add, r_hour_end;

  logic w_mode_press;
  logic w_inc_press;
  logic w_tick;
  logic w_blink_tc;

  assign w_mode_press = key_mode & ~r_mode_q;
  assign w_inc_press  = key_inc & ~r_inc_q;
  assign w_tick       = (r_state == ST_RUN) && (r_presc == PW'(TICK_DIV - 1));
  assign w_blink_tc   = (r_blink_cnt == BW'(BLINK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_mode_q    <= 1'b1;
      r_inc_q     <= 1'b1;
      r_presc     <= '0;
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
      r_sec_add   <= 1'b0;
      r_sec_end   <= 1'b0;
      r_min_add   <= 1'b0;
      r_min_end   <= 1'b0;
      r_hour_add  <= 1'b0;
      r_hour_end  <= 1'b0;
    end else begin
      r_mode_q   <= key_mode;
      r_inc_q    <= key_inc;
      r_sec_add  <= 1'b0;
      r_sec_end  <= 1'b0;
      r_min_add  <= 1'b0;
      r_min_end  <= 1'b0;
      r_hour_add <= 1'b0;
      r_hour_end <= 1'b0;

      if (r_state == ST_RUN) begin
        r_presc     <= w_tick ? '0 : r_presc + PW'(1);
        r_blink     <= 1'b0;
        r_blink_cnt <= '0;
        // Each field either increments or wraps; a wrap ripples one field up.
        if (w_tick) begin
          r_sec_add <= ~sec_carry;
          r_sec_end <= sec_carry;
          if (sec_carry) begin
            r_min_add <= ~min_carry;
            r_min_end <= min_carry;
            if (min_carry) begin
              r_hour_add <= ~hour_carry;
              r_hour_end <= hour_carry;
            end
          end
        end
      end else begin
        r_presc     <= '0;
        r_blink_cnt <= w_blink_tc ? '0 : r_blink_cnt + BW'(1);
        if (w_blink_tc) r_blink <= ~r_blink;
        if (w_inc_press && !w_mode_press) begin
          case (r_state)
            ST_SET_HOUR: begin
              r_hour_add <= ~hour_carry;
              r_hour_end <= hour_carry;
            end
            ST_SET_MIN: begin
              r_min_add <= ~min_carry;
              r_min_end <= min_carry;
            end
            default: begin
              r_sec_add <= ~sec_carry;
              r_sec_end <= sec_carry;
            end
          endcase
        end
      end

      // A mode change restarts the prescaler and shows the new field unblanked.
      if (w_mode_press) begin
        r_state     <= state_t'(r_state + 2'd1);
        r_presc     <= '0;
        r_blink     <= 1'b0;
        r_blink_cnt <= '0;
      end
    end
  end

  assign sec_add  = r_sec_add;
  assign sec_end  = r_sec_end;
  assign min_add  = r_min_add;
  assign min_end  = r_min_end;
  assign hour_add = r_hour_add;
  assign hour_end = r_hour_end;
  assign mode     = r_state;
  assign blink    = r_blink;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl with TICK_DIV=4, BLINK_DIV=3 and a behavioural
// hh:mm:ss counter model driven by the pulse outputs.
module tb_clock_time_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, key_mode, key_inc;
  logic       sec_carry, min_carry, hour_carry;
  logic       sec_add, sec_end, min_add, min_end, hour_add, hour_end;
  logic [1:0] mode;
  logic       blink;
  logic [5:0] w_p;

  int m_sec, m_min, m_hour;
  int n_tests = 0;
  int n_fail  = 0;
  int cnt_sec_p, cnt_min_p, cnt_both;

  always #5 clk = ~clk;

  assign sec_carry  = (m_sec == 59);
  assign min_carry  = (m_min == 59);
  assign hour_carry = (m_hour == 23);
  // bit order: sec_add sec_end min_add min_end hour_add hour_end
  assign w_p = {sec_add, sec_end, min_add, min_end, hour_add, hour_end};

  clock_time_ctrl #(.TICK_DIV(4), .BLINK_DIV(3)) dut (
    .clk(clk), .rst_n(rst_n), .key_mode(key_mode), .key_inc(key_inc),
    .sec_carry(sec_carry), .min_carry(min_carry), .hour_carry(hour_carry),
    .sec_add(sec_add), .sec_end(sec_end), .min_add(min_add), .min_end(min_end),
    .hour_add(hour_add), .hour_end(hour_end), .mode(mode), .blink(blink)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge; the model absorbs the pulses seen there.
  task automatic step();
    @(negedge clk);
    if ((sec_add & sec_end) | (min_add & min_end) | (hour_add & hour_end)) cnt_both++;
    cnt_sec_p += int'(sec_add | sec_end);
    cnt_min_p += int'(min_add | min_end);
    if (sec_end) m_sec = 0; else if (sec_add) m_sec++;
    if (min_end) m_min = 0; else if (min_add) m_min++;
    if (hour_end) m_hour = 0; else if (hour_add) m_hour++;
  endtask

  task automatic wait_pulse(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (w_p == 6'b0 && n < 20);
  endtask

  function automatic int hms();
    return m_hour * 10000 + m_min * 100 + m_sec;
  endfunction

  initial begin
    int n, bad;
    logic [5:0] inc_exp [3];
    int         hr_exp  [3];
    logic [1:0] md_exp  [4];
    inc_exp = '{6'b000010, 6'b000001, 6'b000010};
    hr_exp  = '{23, 0, 1};
    md_exp  = '{2'd1, 2'd2, 2'd3, 2'd0};

    rst_n = 1'b0; key_mode = 1'b1; key_inc = 1'b0;
    m_sec = 0; m_min = 0; m_hour = 0;
    cnt_sec_p = 0; cnt_min_p = 0; cnt_both = 0;
    repeat (3) step();
    check_val("rst_mode", mode, 0);
    check_val("rst_pulses", w_p, 0);
    check_val("rst_blink", blink, 0);

    // release reset with the mode key still held
    rst_n = 1'b1;
    n = 0; bad = 0;
    do begin
      step();
      n++;
      if (mode != 2'd0 || (w_p != 6'b0 && w_p != 6'b100000)) bad++;
    end while (!sec_add && n < 20);
    check_val("first_tick_latency", n, 4);
    check_val("held_key_no_press", bad, 0);
    check_val("first_tick_pulse", w_p, 6'b100000);
    key_mode = 1'b0;
    wait_pulse(n);
    check_val("tick_period", n, 4);
    check_val("sec_after_two_ticks", m_sec, 2);

    key_inc = 1'b1;
    step();
    check_val("inc_in_run_ignored", w_p, 0);
    key_inc = 1'b0;
    step();

    m_sec = 59; m_min = 0; m_hour = 0;
    wait_pulse(n);
    check_val("carry_sec_to_min", w_p, 6'b011000);
    step();
    check_val("carry_pulse_width", w_p, 0);
    check_val("time_00_01_00", hms(), 100);

    m_sec = 59; m_min = 59; m_hour = 23;
    wait_pulse(n);
    check_val("wrap_all_fields", w_p, 6'b010101);
    step();
    check_val("wrap_pulse_width", w_p, 0);
    check_val("time_00_00_00", hms(), 0);

    // SET_HOUR: blink cadence and isolated hour stepping
    m_hour = 22;
    key_mode = 1'b1;
    step();
    check_val("mode_set_hour", mode, 1);
    key_mode = 1'b0;
    cnt_sec_p = 0; cnt_min_p = 0;
    check_val("blink_t0", blink, 0);
    repeat (2) step();
    check_val("blink_t2", blink, 0);
    step();
    check_val("blink_t3", blink, 1);
    repeat (3) step();
    check_val("blink_t6", blink, 0);
    for (int i = 0; i < 3; i++) begin
      key_inc = 1'b1;
      step();
      check_val($sformatf("set_hour_pulse%0d", i), w_p, inc_exp[i]);
      key_inc = 1'b0;
      step();
      check_val($sformatf("set_hour_value%0d", i), m_hour, hr_exp[i]);
    end
    check_val("set_hour_isolation", cnt_sec_p + cnt_min_p, 0);

    // SET_MIN: wrap at 59, then simultaneous mode+inc
    key_mode = 1'b1;
    step();
    check_val("mode_set_min", mode, 2);
    check_val("blink_clear_on_mode", blink, 0);
    key_mode = 1'b0;
    step();
    m_min = 59;
    key_inc = 1'b1;
    step();
    check_val("set_min_end", w_p, 6'b000100);
    key_inc = 1'b0;
    step();
    check_val("set_min_value", m_min, 0);
    key_mode = 1'b1; key_inc = 1'b1;
    step();
    check_val("mode_wins", mode, 3);
    check_val("inc_discarded", w_p, 0);
    key_mode = 1'b0; key_inc = 1'b0;
    step();
    check_val("inc_discarded_after", w_p, 0);
    check_val("min_unchanged", m_min, 0);

    key_mode = 1'b1;
    step();
    check_val("mode_back_run", mode, 0);
    key_mode = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      key_mode = 1'b1;
      step();
      check_val($sformatf("mode_seq%0d", i), mode, md_exp[i]);
      key_mode = 1'b0;
      if (i < 3) step();
    end
    n = 0; bad = 0;
    do begin
      step();
      n++;
      if (blink) bad++;
    end while (!sec_add && n < 20);
    check_val("reentry_tick_latency", n, 4);
    check_val("blink_off_in_run", bad, 0);

    // reset asserted in the tick-trigger cycle
    repeat (3) step();
    rst_n = 1'b0;
    step();
    check_val("rst_suppresses_tick", w_p, 0);
    rst_n = 1'b1;
    step();
    check_val("no_pulse_after_rst", w_p, 0);
    check_val("mode_after_rst", mode, 0);
    check_val("add_end_exclusive", cnt_both, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
